datapath_sequencer: RTL and testbench

//  Command-driven controller for the register-file/ALU/memory datapath (DatapathRegALU).

---
 rtl/datapath_sequencer.sv | 174 +++++++++++++++++
 tb/tb_datapath_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Micro-op sequencer for the register-file/ALU/memory datapath.
// Takes one command per handshake and drives the datapath control word until the op commits.
module datapath_sequencer #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_da,
    input  logic [REG_AW-1:0] cmd_sa,
    input  logic [REG_AW-1:0] cmd_sb,
    input  logic [4:0]        cmd_fs,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [REG_AW-1:0] DA,
    output logic [REG_AW-1:0] SA,
    output logic [REG_AW-1:0] SB,
    output logic              W,
    output logic [DATA_W-1:0] K,
    output logic              BS,
    output logic [4:0]        FS,
    output logic              write,
    output logic              selEN,
    input  logic [3:0]        status,
    output logic              done,
    output logic [3:0]        status_q,
    output logic              err
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [REG_AW-1:0] ZERO_REG = '1;
    localparam logic [4:0] FS_PASS = 5'b00100;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU_REG = 3'b000,
        OP_ALU_IMM = 3'b001,
        OP_STORE   = 3'b010,
        OP_LOAD    = 3'b011,
        OP_NOP     = 3'b100
    } op_t;

    state_t            state, state_next;
    op_t               op_q;
    logic [REG_AW-1:0] da_q, sa_q, sb_q;
    logic [4:0]        fs_q;
    logic [DATA_W-1:0] imm_q;
    logic [CW-1:0]     cnt;
    logic              accept;
    logic              last;
    logic              is_mem_cmd;
    logic              is_alu_q;

    assign is_mem_cmd = (cmd_op == OP_STORE) || (cmd_op == OP_LOAD);
    assign is_alu_q   = (op_q == OP_ALU_REG) || (op_q == OP_ALU_IMM);
    assign last       = (cnt == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control word depends only on state and registered command, so an async
    // reset forcing IDLE drops every enable immediately.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cmd_ready  = 1'b0;
        DA         = '0;
        SA         = '1;
        SB         = '1;
        W          = 1'b0;
        K          = '0;
        BS         = 1'b0;
        FS         = '0;
        write      = 1'b0;
        selEN      = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                done = last;
                if (last) begin
                    state_next = IDLE;
                end
                case (op_q)
                    OP_ALU_REG: begin
                        DA = da_q;
                        SA = sa_q;
                        SB = sb_q;
                        FS = fs_q;
                        W  = last && (da_q != ZERO_REG);
                    end
                    OP_ALU_IMM: begin
                        DA = da_q;
                        SA = sa_q;
                        FS = fs_q;
                        BS = 1'b1;
                        K  = imm_q;
                        W  = last && (da_q != ZERO_REG);
                    end
                    OP_STORE: begin
                        SA    = sa_q;
                        SB    = sb_q;
                        K     = imm_q;
                        BS    = 1'b1;
                        FS    = FS_PASS;
                        write = last;
                    end
                    OP_LOAD: begin
                        DA    = da_q;
                        SA    = sa_q;
                        K     = imm_q;
                        BS    = 1'b1;
                        FS    = FS_PASS;
                        selEN = 1'b0;
                        W     = last && (da_q != ZERO_REG);
                    end
                    default: ;
                endcase
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q     <= OP_NOP;
            da_q     <= '0;
            sa_q     <= '1;
            sb_q     <= '1;
            fs_q     <= '0;
            imm_q    <= '0;
            cnt      <= '0;
            status_q <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= op_t'(cmd_op);
                da_q  <= cmd_da;
                sa_q  <= cmd_sa;
                sb_q  <= cmd_sb;
                fs_q  <= cmd_fs;
                imm_q <= cmd_imm;
                cnt   <= is_mem_cmd ? CW'(MEM_LAT - 1) : '0;
                if (cmd_op > OP_NOP) begin
                    err <= 1'b1;
                end
            end else if (state == EXEC && !last) begin
                cnt <= cnt - CW'(1);
            end
            if (done && is_alu_q) begin
                status_q <= status;
            end
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer with a small behavioural datapath model
// (register file, OR/ADD/XOR/shift ALU, 32-word memory) closing the loop.
module tb_datapath_sequencer;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned MEM_LAT = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [4:0]        cmd_da = '0, cmd_sa = '0, cmd_sb = '0, cmd_fs = '0;
    logic [63:0]       cmd_imm = '0;
    logic [4:0]        DA, SA, SB, FS;
    logic              W, BS, write, selEN, done, err;
    logic [63:0]       K;
    logic [3:0]        status, status_q;

    always #5 clock = ~clock;

    datapath_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_LAT(MEM_LAT)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_da(cmd_da), .cmd_sa(cmd_sa), .cmd_sb(cmd_sb),
        .cmd_fs(cmd_fs), .cmd_imm(cmd_imm), .DA(DA), .SA(SA), .SB(SB), .W(W),
        .K(K), .BS(BS), .FS(FS), .write(write), .selEN(selEN), .status(status),
        .done(done), .status_q(status_q), .err(err)
    );

    typedef struct packed {
        logic [4:0]  da;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic        w;
        logic [63:0] k;
        logic        bs;
        logic [4:0]  fs;
        logic        wr;
        logic        sel;
    } ctrl_t;

    localparam ctrl_t RST = '{da: 5'd0, sa: 5'h1f, sb: 5'h1f, w: 1'b0, k: 64'd0,
                              bs: 1'b0, fs: 5'd0, wr: 1'b0, sel: 1'b1};

    typedef struct {
        ctrl_t           ctrl;
        int unsigned     delta;
        longint unsigned acc;
        logic [3:0]      st;
        logic [2:0]      op;
    } exp_t;

    ctrl_t act;
    assign act = {DA, SA, SB, W, K, BS, FS, write, selEN};

    // Datapath model driven by the DUT's control word
    logic [63:0] rf [32];
    logic [63:0] mem [32];
    logic [63:0] a_v, b_v, f_v, bus_v;
    always_comb begin
        a_v = (SA == 5'd31) ? 64'd0 : rf[SA];
        b_v = BS ? K : ((SB == 5'd31) ? 64'd0 : rf[SB]);
        case (FS[4:2])
            3'd0:    f_v = a_v & b_v;
            3'd1:    f_v = a_v | b_v;
            3'd2:    f_v = a_v + b_v;
            3'd3:    f_v = a_v ^ b_v;
            3'd4:    f_v = a_v << b_v[5:0];
            3'd5:    f_v = a_v >> b_v[5:0];
            default: f_v = 64'd0;
        endcase
        bus_v = selEN ? f_v : mem[f_v[4:0]];
    end
    assign status = f_v[3:0];
    always @(posedge clock) begin
        if (W && DA != 5'd31) rf[DA] <= bus_v;
        if (write) mem[f_v[4:0]] <= (SB == 5'd31) ? 64'd0 : rf[SB];
    end

    longint unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    exp_t        sbq[$];
    int unsigned checks = 0, errors = 0;
    int unsigned w_cycles = 0, wr_cycles = 0, sel0_cycles = 0, overlap = 0, done_cnt = 0;
    logic        st_pending = 1'b0;
    logic [3:0]  st_exp = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clock) begin
        exp_t e;
        if (st_pending) begin
            check("status_q", 64'(status_q), 64'(st_exp));
            st_pending = 1'b0;
        end
        if (W && write) overlap++;
        if (W) w_cycles++;
        if (write) wr_cycles++;
        if (!selEN) sel0_cycles++;
        if (done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d got done=1 want none", cyc);
            end else begin
                e = sbq.pop_front();
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl op%0d got %h want %h", e.op, act, e.ctrl);
                end
                check("done_latency", 64'(cyc - e.acc), 64'(e.delta));
                st_pending = 1'b1;
                st_exp     = e.st;
            end
        end
    end

    function automatic ctrl_t exp_ctrl(input logic [2:0] op, input logic [4:0] da, sa, sb, fs,
                                       input logic [63:0] imm);
        ctrl_t c = RST;
        case (op)
            3'd0: begin c.da = da; c.sa = sa; c.sb = sb; c.fs = fs; c.w = (da != 5'd31); end
            3'd1: begin c.da = da; c.sa = sa; c.fs = fs; c.bs = 1'b1; c.k = imm; c.w = (da != 5'd31); end
            3'd2: begin c.sa = sa; c.sb = sb; c.k = imm; c.bs = 1'b1; c.fs = 5'b00100; c.wr = 1'b1; end
            3'd3: begin c.da = da; c.sa = sa; c.k = imm; c.bs = 1'b1; c.fs = 5'b00100; c.sel = 1'b0;
                        c.w = (da != 5'd31); end
            default: ;
        endcase
        return c;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [4:0] da, sa, sb, fs,
                         input logic [63:0] imm, input logic [3:0] st, input bit hold,
                         output int unsigned waited);
        exp_t e;
        @(negedge clock);
        cmd_op = op; cmd_da = da; cmd_sa = sa; cmd_sb = sb; cmd_fs = fs; cmd_imm = imm;
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got cmd_ready=0 want 1");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        e.ctrl  = exp_ctrl(op, da, sa, sb, fs, imm);
        e.delta = (op == 3'd2 || op == 3'd3) ? MEM_LAT - 1 : 0;
        e.acc   = cyc;
        e.st    = st;
        e.op    = op;
        sbq.push_back(e);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((sbq.size() != 0 || st_pending) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0 || st_pending) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", sbq.size());
            sbq.delete();
            st_pending = 1'b0;
        end
        @(negedge clock);
    endtask

    initial begin
        int unsigned w0, w1, w2, wr0, sel0, d0;
        repeat (3) @(negedge clock);
        check("rst_ctrl", 64'(act == RST), 64'd1);
        check("rst_flags", {60'd0, done, status_q[2:0]}, 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_ready", 64'(cmd_ready), 64'd1);

        // 1: single ALU_IMM
        issue(3'b001, 5'd5, 5'd31, 5'd0, 5'b00100, 64'd24, 4'h8, 1'b0, w0);
        drain();
        check("t1_w_pulses", 64'(w_cycles), 64'd1);
        check("t1_r5", rf[5], 64'd24);

        // 2: short program
        d0 = done_cnt;
        issue(3'b001, 5'd7,  5'd31, 5'd0, 5'b00100, 64'd39, 4'h7, 1'b0, w0);
        issue(3'b000, 5'd1,  5'd5,  5'd7, 5'b01000, 64'd0,  4'hF, 1'b0, w0);
        issue(3'b000, 5'd30, 5'd1,  5'd5, 5'b01100, 64'd0,  4'h7, 1'b0, w0);
        issue(3'b001, 5'd17, 5'd30, 5'd0, 5'b10000, 64'd2,  4'hC, 1'b0, w0);
        drain();
        check("t2_r1", rf[1], 64'd63);
        check("t2_r30", rf[30], 64'd39);
        check("t2_r17", rf[17], 64'd156);
        check("t2_dones", 64'(done_cnt - d0), 64'd4);

        // 3: STORE then LOAD
        wr0 = wr_cycles;
        issue(3'b010, 5'd0, 5'd7, 5'd17, 5'd0, 64'd0, 4'hC, 1'b0, w0);
        drain();
        check("t3_write_cycles", 64'(wr_cycles - wr0), 64'd1);
        sel0 = sel0_cycles;
        issue(3'b011, 5'd0, 5'd7, 5'd0, 5'd0, 64'd0, 4'hC, 1'b0, w0);
        drain();
        check("t3_sel0_cycles", 64'(sel0_cycles - sel0), 64'd2);
        check("t3_r0", rf[0], 64'd156);

        // 4: zero-register write suppression, illegal op, sticky err
        w1 = w_cycles;
        issue(3'b001, 5'd31, 5'd31, 5'd0, 5'b00100, 64'd5, 4'h5, 1'b0, w0);
        drain();
        check("t4_w_suppressed", 64'(w_cycles - w1), 64'd0);
        issue(3'b111, 5'd3, 5'd3, 5'd3, 5'b01000, 64'd9, 4'h5, 1'b0, w0);
        drain();
        check("t4_err_set", 64'(err), 64'd1);
        issue(3'b100, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 4'h5, 1'b0, w0);
        drain();
        check("t4_err_sticky", 64'(err), 64'd1);

        // 5: reset during first EXEC cycle of a STORE
        wr0 = wr_cycles;
        d0  = done_cnt;
        issue(3'b010, 5'd0, 5'd7, 5'd17, 5'd0, 64'd0, 4'h5, 1'b0, w0);
        #1 reset = 1'b0;
        #1;
        check("t5_ctrl_reset", 64'(act == RST), 64'd1);
        sbq.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t5_ready", 64'(cmd_ready), 64'd1);
        check("t5_no_write", 64'(wr_cycles - wr0), 64'd0);
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check("t5_err_clear", {59'd0, err, status_q}, 64'd0);

        // 6: cmd_valid held across three ops
        issue(3'b001, 5'd2, 5'd31, 5'd0, 5'b00100, 64'd3, 4'h3, 1'b1, w0);
        issue(3'b000, 5'd3, 5'd2,  5'd2, 5'b01000, 64'd0, 4'h6, 1'b1, w1);
        issue(3'b001, 5'd4, 5'd3,  5'd0, 5'b01100, 64'd1, 4'h7, 1'b0, w2);
        drain();
        check("t6_wait1", 64'(w1), 64'd1);
        check("t6_wait2", 64'(w2), 64'd1);
        check("t6_r2", rf[2], 64'd3);
        check("t6_r3", rf[3], 64'd6);
        check("t6_r4", rf[4], 64'd7);
        check("t6_status_q", 64'(status_q), 64'd7);
        check("no_w_write_overlap", 64'(overlap), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
